operand_fetch: RTL

OPERAND_FETCH -- requirements
Module: operand_fetch

---
 rtl/riscv_pkg.sv | 22 ++
 rtl/reg_scoreboard.sv | 33 +++
 rtl/operand_fetch.sv | 81 ++++++++
 3 files changed

// File: rtl/riscv_pkg.sv
// riscv_pkg: shared widths, RV32 major opcodes and the id_ex payload carried from operand fetch to execute
package riscv_pkg;
  localparam int XLEN = 32;
  localparam int NREG = 32;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_OP     = 7'b0110011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [31:0]     instr;
    logic [XLEN-1:0] rs1_val;
    logic [XLEN-1:0] rs2_val;
    logic [4:0]      rd;
    logic            rd_we;
  } id_ex_t;
endpackage

// File: rtl/reg_scoreboard.sv
// reg_scoreboard: pending-write vector (set on issue, cleared by writeback or kill, set wins) with rs1/rs2/rd hazard query
module reg_scoreboard import riscv_pkg::*; #(
  parameter int NREG = riscv_pkg::NREG
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] rs1_i,
  input  logic [4:0] rs2_i,
  input  logic [4:0] rd_i,
  input  logic       use1_i,
  input  logic       use2_i,
  input  logic       rd_we_i,
  input  logic       set_i,
  input  logic       wb_we_i,
  input  logic [4:0] wb_addr_i,
  input  logic       kill_i,
  input  logic [4:0] kill_addr_i,
  output logic       hazard_o
);
  logic [NREG-1:0] pend_q, pend_d;
  function automatic logic busy(input logic [4:0] a);
    return pend_q[a] && !(wb_we_i && wb_addr_i == a);
  endfunction
  for (genvar r = 0; r < NREG; r++) begin : g_p
    assign pend_d[r] = (r == 0) ? 1'b0 :
                       (set_i && rd_i == 5'(r)) ? 1'b1 :
                       ((wb_we_i && wb_addr_i == 5'(r)) || (kill_i && kill_addr_i == 5'(r))) ? 1'b0 :
                       pend_q[r];
  end
  assign hazard_o = (use1_i && busy(rs1_i)) || (use2_i && busy(rs2_i)) || (rd_we_i && busy(rd_i));
  always_ff @(posedge clk)
    pend_q <= rst ? '0 : pend_d;
endmodule

// File: rtl/operand_fetch.sv
// operand_fetch: decode rs1/rs2/rd, read+bypass operands, stall on scoreboard hazards, register id_ex payload with valid/ready
module operand_fetch import riscv_pkg::*; #(
  parameter int XLEN = riscv_pkg::XLEN,
  parameter int NREG = riscv_pkg::NREG
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            i_valid,
  input  logic [XLEN-1:0] i_pc,
  input  logic [31:0]     i_instr,
  output logic            o_ready,
  output logic [4:0]      o_raddr1,
  output logic [4:0]      o_raddr2,
  input  logic [XLEN-1:0] i_rdata1,
  input  logic [XLEN-1:0] i_rdata2,
  input  logic            i_wb_we,
  input  logic [4:0]      i_wb_waddr,
  input  logic [XLEN-1:0] i_wb_wdata,
  input  logic            i_flush,
  input  logic            i_ready,
  output logic            o_valid,
  output logic [XLEN-1:0] o_pc,
  output logic [31:0]     o_instr,
  output logic [XLEN-1:0] o_rs1_val,
  output logic [XLEN-1:0] o_rs2_val,
  output logic [4:0]      o_rd,
  output logic            o_rd_we
);
  logic [6:0] opc;
  logic [4:0] rs1, rs2, rd;
  logic use1, use2, rd_we, wb_hit, hazard, fire, valid_q;
  logic [XLEN-1:0] op1, op2;
  id_ex_t out_q, out_d;
  assign opc = i_instr[6:0];
  assign rs1 = i_instr[19:15];
  assign rs2 = i_instr[24:20];
  assign rd = i_instr[11:7];
  assign o_raddr1 = rs1;
  assign o_raddr2 = rs2;
  assign use1 = !(opc inside {OP_LUI, OP_AUIPC, OP_JAL});
  assign use2 = opc inside {OP_OP, OP_STORE, OP_BRANCH};
  assign rd_we = (rd != 5'd0) && (opc inside {OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_LOAD, OP_IMM, OP_OP});
  assign wb_hit = i_wb_we && i_wb_waddr != 5'd0;
  assign op1 = (rs1 == 5'd0) ? '0 : (wb_hit && i_wb_waddr == rs1) ? i_wb_wdata : i_rdata1;
  assign op2 = (rs2 == 5'd0) ? '0 : (wb_hit && i_wb_waddr == rs2) ? i_wb_wdata : i_rdata2;
  assign o_ready = !i_flush && !hazard && (!valid_q || i_ready);
  assign fire = i_valid && o_ready;
  assign out_d = '{pc: i_pc, instr: i_instr, rs1_val: op1, rs2_val: op2, rd: rd, rd_we: rd_we};
  reg_scoreboard #(.NREG(NREG)) u_sb (
    .clk         (clk),
    .rst         (rst),
    .rs1_i       (rs1),
    .rs2_i       (rs2),
    .rd_i        (rd),
    .use1_i      (use1),
    .use2_i      (use2),
    .rd_we_i     (rd_we),
    .set_i       (fire && rd_we),
    .wb_we_i     (wb_hit),
    .wb_addr_i   (i_wb_waddr),
    .kill_i      (i_flush && valid_q && out_q.rd_we && !i_ready),
    .kill_addr_i (out_q.rd),
    .hazard_o    (hazard)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      out_q <= '0;
    end else begin
      valid_q <= fire || (valid_q && !i_ready && !i_flush);
      if (fire) out_q <= out_d;
    end
  end
  assign o_valid = valid_q;
  assign o_pc = out_q.pc;
  assign o_instr = out_q.instr;
  assign o_rs1_val = out_q.rs1_val;
  assign o_rs2_val = out_q.rs2_val;
  assign o_rd = out_q.rd;
  assign o_rd_we = out_q.rd_we;
endmodule
